// File: rtl/router_register_p.sv
// Parametrised router packet register: header capture, HOLD_DEPTH beat holding queue, running XOR parity check.
// Latency: a beat accepted at edge N into an empty queue appears on dout/dout_valid after edge N+1; 1 beat/cycle.
// Backpressure: fifo_full stalls the output pop; in_ready drops when the queue holds HOLD_DEPTH beats (registered count only).
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   data_in, in_valid, in_ready beat input handshake (accept = in_valid && in_ready)
//   pkt_valid                   1 on header/payload beats, 0 on the parity beat
//   fifo_full                   destination FIFO backpressure
//   dout, dout_valid            forwarded beat stream
//   dest                        destination field of the current/last header
//   parity_done, err, len_err, low_pkt_valid   sticky per-packet status, cleared by the next header
//
// Optional feature macro: ROUTER_REG_LEN_CHECK_EN builds the payload counter and
// length compare; when undefined len_err is tied to 0.
module router_register_p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 2,
    parameter int HOLD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    input  logic                  pkt_valid,
    output logic                  in_ready,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_W-1:0]     dest,
    output logic                  parity_done,
    output logic                  err,
    output logic                  len_err,
    output logic                  low_pkt_valid
);

    localparam int PTR_W = $clog2(HOLD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_PAYLOAD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_accept;
    logic                  w_hdr;
    logic                  w_body;
    logic                  w_par;
    logic                  w_push;
    logic                  w_pop;

    logic [DATA_WIDTH-1:0] r_mem [HOLD_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_vld;
    logic [ADDR_W-1:0]     r_dest;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_parity_done;
    logic                  r_err;
    logic                  r_low_pkt_valid;

    // in_ready depends only on the registered count, so fifo_full never
    // reaches it combinationally; a pop while full raises it one cycle later.
    assign in_ready = (r_count < CNT_W'(HOLD_DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !fifo_full;
    // Parity-less beats seen in IDLE are dropped, not queued.
    assign w_push   = w_hdr || w_body || w_par;

    // ---------------- packet FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr       = 1'b0;
        w_body      = 1'b0;
        w_par       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && pkt_valid) begin
                    w_hdr       = 1'b1;
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    if (pkt_valid) begin
                        w_body = 1'b1;
                    end else begin
                        w_par       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- holding queue ----------------
    // Storage is not reset; only pointers and count need a defined value.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // Pointers wrap naturally because HOLD_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- output stage ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_pop;
            if (w_pop) r_dout <= r_mem[r_rptr];
        end
    end

    // ---------------- header / parity tracking ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dest          <= '0;
            r_acc           <= '0;
            r_parity_done   <= 1'b0;
            r_err           <= 1'b0;
            r_low_pkt_valid <= 1'b0;
        end else if (w_hdr) begin
            r_dest          <= data_in[ADDR_W-1:0];
            r_acc           <= data_in;
            r_parity_done   <= 1'b0;
            r_err           <= 1'b0;
            r_low_pkt_valid <= 1'b0;
        end else if (w_body) begin
            r_acc <= r_acc ^ data_in;
        end else if (w_par) begin
            r_parity_done   <= 1'b1;
            r_low_pkt_valid <= 1'b1;
            r_err           <= (r_acc != data_in);
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam int LEN_W = DATA_WIDTH - ADDR_W;

    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pay_cnt;
    logic             r_len_err;

    // Counter saturates so an overlong packet cannot wrap back to a match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_len     <= '0;
            r_pay_cnt <= '0;
            r_len_err <= 1'b0;
        end else if (w_hdr) begin
            r_len     <= data_in[DATA_WIDTH-1:ADDR_W];
            r_pay_cnt <= '0;
            r_len_err <= 1'b0;
        end else if (w_body) begin
            if (r_pay_cnt != '1) r_pay_cnt <= r_pay_cnt + LEN_W'(1);
        end else if (w_par) begin
            r_len_err <= (r_pay_cnt != r_len);
        end
    end

    assign len_err = r_len_err;
`else
    assign len_err = 1'b0;
`endif

    assign dout          = r_dout;
    assign dout_valid    = r_dout_vld;
    assign dest          = r_dest;
    assign parity_done   = r_parity_done;
    assign err           = r_err;
    assign low_pkt_valid = r_low_pkt_valid;

endmodule

// File: tb/tb_router_register_p.sv
// Directed bench for router_register_p (W=8, ADDR_W=2, HOLD_DEPTH=4).
// Latency: n/a (testbench).
// Backpressure: drives fifo_full directly to exercise the holding queue.
module tb_router_register_p;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       pkt_valid = 1'b0;
    logic       in_ready;
    logic       fifo_full = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] dest;
    logic       parity_done;
    logic       err;
    logic       len_err;
    logic       low_pkt_valid;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] got_d[$];
    int         got_c[$];

`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam logic EXP_SHORT_LEN_ERR = 1'b1;
`else
    localparam logic EXP_SHORT_LEN_ERR = 1'b0;
`endif

    router_register_p #(.DATA_WIDTH(8), .ADDR_W(2), .HOLD_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .in_valid(in_valid),
        .pkt_valid(pkt_valid), .in_ready(in_ready), .fifo_full(fifo_full),
        .dout(dout), .dout_valid(dout_valid), .dest(dest),
        .parity_done(parity_done), .err(err), .len_err(len_err),
        .low_pkt_valid(low_pkt_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record every forwarded beat with its cycle index.
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            got_d.push_back(dout);
            got_c.push_back(cyc);
        end
    end

    task automatic beat(input logic [7:0] d, input logic pv, output int acc_cyc);
        data_in   = d;
        pkt_valid = pv;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(1);
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(2);
        n_vec++;
        if ({dout_valid, dout, dest, parity_done, err, len_err, low_pkt_valid} !== 15'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: dout_valid=%b dout=%h dest=%0d pd=%b err=%b lerr=%b low=%b in_ready=%b (want all 0, in_ready=1)",
                     dout_valid, dout, dest, parity_done, err, len_err, low_pkt_valid, in_ready);
        end
        resetn = 1'b1;
        idle(1);
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_d[5];
        int a0, a;
        exp_d = '{8'h0C, 8'hFF, 8'hFF, 8'hFF, 8'hF3};
        beat(8'h0C, 1'b1, a0);
        n_vec++;
        if (dest !== 2'd0 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL good_hdr: dest=%0d pd=%b low=%b (want 0,0,0)", dest, parity_done, low_pkt_valid);
        end
        for (int i = 1; i < 4; i++) beat(8'hFF, 1'b1, a);
        beat(8'hF3, 1'b0, a);
        n_vec++;
        if ({parity_done, err, len_err, low_pkt_valid} !== 4'b1001) begin
            n_bad++;
            $display("FAIL good_flags: pd/err/lerr/low=%b want 1001", {parity_done, err, len_err, low_pkt_valid});
        end
        idle(4);
        n_vec++;
        if (got_d.size() != 5) begin
            n_bad++;
            $display("FAIL good_count: got %0d beats want 5", got_d.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (got_d[i] !== exp_d[i] || got_c[i] != a0 + 1 + i) begin
                    n_bad++;
                    $display("FAIL good_beat%0d: dout=%h cyc=%0d want %h cyc=%0d",
                             i, got_d[i], got_c[i], exp_d[i], a0 + 1 + i);
                end
            end
        end
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_bad_parity();
        int a;
        beat(8'h0C, 1'b1, a);
        for (int i = 0; i < 3; i++) beat(8'hFF, 1'b1, a);
        beat(8'hFB, 1'b0, a);
        n_vec++;
        if (err !== 1'b1 || parity_done !== 1'b1) begin
            n_bad++;
            $display("FAIL badpar_err: err=%b pd=%b want 1,1", err, parity_done);
        end
        idle(2);
        n_vec++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL badpar_sticky: err=%b want 1", err);
        end
        beat(8'h05, 1'b1, a);
        n_vec++;
        if (err !== 1'b0 || dest !== 2'd1 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL badpar_clear: err=%b dest=%0d pd=%b low=%b want 0,1,0,0", err, dest, parity_done, low_pkt_valid);
        end
        idle(4);
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_short_packet();
        int a;
        do_reset();
        beat(8'h0C, 1'b1, a);
        beat(8'hFF, 1'b1, a);
        beat(8'hFF, 1'b1, a);
        beat(8'hF3, 1'b0, a);
        n_vec++;
        if (err !== 1'b1 || len_err !== EXP_SHORT_LEN_ERR || low_pkt_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL short_pkt: err=%b len_err=%b low=%b want 1,%b,1", err, len_err, low_pkt_valid, EXP_SHORT_LEN_ERR);
        end
        idle(4);
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] vec[6];
        int  accepted;
        logic rdy_before;
        int  first_pop;
        vec = '{8'h1C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        accepted  = 0;
        fifo_full = 1'b1;
        for (int c = 0; c < 6; c++) begin
            data_in    = vec[accepted];
            pkt_valid  = 1'b1;
            in_valid   = 1'b1;
            rdy_before = in_ready;
            @(posedge clk);
            #1;
            if (rdy_before) begin
                accepted++;
                if (accepted == 4) begin
                    n_vec++;
                    if (in_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL bp_ready_drop: in_ready=%b want 0", in_ready);
                    end
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (accepted != 4 || in_ready !== 1'b0 || got_d.size() != 0) begin
            n_bad++;
            $display("FAIL bp_fill: accepted=%0d in_ready=%b dout_beats=%0d want 4,0,0", accepted, in_ready, got_d.size());
        end
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        first_pop = cyc;
        n_vec++;
        if (in_ready !== 1'b1 || dout_valid !== 1'b1 || dout !== 8'h1C) begin
            n_bad++;
            $display("FAIL bp_first_pop: in_ready=%b dout_valid=%b dout=%h want 1,1,1c", in_ready, dout_valid, dout);
        end
        idle(5);
        n_vec++;
        if (got_d.size() != 4) begin
            n_bad++;
            $display("FAIL bp_drain_count: got %0d beats want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (got_d[i] !== vec[i] || got_c[i] != first_pop + i) begin
                    n_bad++;
                    $display("FAIL bp_drain%0d: dout=%h cyc=%0d want %h cyc=%0d", i, got_d[i], got_c[i], vec[i], first_pop + i);
                end
            end
        end
        got_d.delete();
        got_c.delete();
    endtask

    task automatic test_reset_midpacket();
        int a;
        do_reset();
        beat(8'h0E, 1'b1, a);
        beat(8'hFF, 1'b1, a);
        n_vec++;
        if (dest !== 2'd2 || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: dest=%0d dout_valid=%b want 2,1", dest, dout_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({dout_valid, dout, dest, parity_done, err, len_err, low_pkt_valid} !== 15'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_async_reset: dout_valid=%b dout=%h dest=%0d in_ready=%b want 0,00,0,1", dout_valid, dout, dest, in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        got_d.delete();
        got_c.delete();
        beat(8'h0D, 1'b0, a);
        idle(3);
        n_vec++;
        if (got_d.size() != 0 || dest !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_discard: dout_beats=%0d dest=%0d want 0,0", got_d.size(), dest);
        end
        beat(8'h07, 1'b1, a);
        n_vec++;
        if (dest !== 2'd3) begin
            n_bad++;
            $display("FAIL mid_new_hdr: dest=%0d want 3", dest);
        end
        idle(3);
        n_vec++;
        if (got_d.size() != 1 || got_d[0] !== 8'h07) begin
            n_bad++;
            $display("FAIL mid_hdr_fwd: beats=%0d first=%h want 1,07", got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_short_packet();
        test_backpressure();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
